dac_sample_feeder: RTL

Stereo sample scheduler in front of the DAC serializer. Buffers stereo sample pairs from a producer (FM synth core or CPU I/O port) in a small FIFO. Pops exactly one pair per DAC frame on the serializer's `next` pulse. Handles prefill, underrun, and a low-watermark refill request.

---
 rtl/dac_sample_feeder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dac_sample_feeder.sv
// Stereo sample scheduler feeding the DAC serializer: FIFO of {L,R} pairs,
// one pop per frame strobe, prefill gating, underrun policy and refill request.
module dac_sample_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int PREFILL    = 8,
    parameter int LOW_WM     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  hold_mode,
    input  logic [15:0]           wr_l,
    input  logic [15:0]           wr_r,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  next,
    output logic [15:0]           sample_l,
    output logic [15:0]           sample_r,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  low,
    output logic                  running,
    output logic [15:0]           underrun_cnt,
    input  logic                  clr_underrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_PRE  = LW'(PREFILL);
    localparam logic [LW-1:0] LVL_LOW  = LW'(LOW_WM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFILL,
        S_RUN
    } state_e;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [31:0]           sample_q, sample_d;
    logic [31:0]           last_q, last_d;
    logic [15:0]           ucnt_q, ucnt_d;
    logic [31:0]           mem_q [DEPTH];

    logic        wr_en;
    logic        frame_run;
    logic        pop;
    logic        underrun;
    logic [31:0] head;
    logic [31:0] hold_pair;

    always_comb begin
        wr_ready  = (state_q != S_IDLE) && (level_q != LVL_FULL);
        wr_en     = wr_valid && wr_ready && enable;
        frame_run = (state_q == S_RUN) && next && enable;
        pop       = frame_run && (level_q != '0);
        underrun  = frame_run && (level_q == '0);
        head      = mem_q[rd_ptr_q];
        hold_pair = hold_mode ? last_q : 32'h0;
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        sample_d = sample_q;
        last_d   = last_q;
        ucnt_d   = ucnt_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + LW'(wr_en) - LW'(pop);

        if (!enable) begin
            // Flush on disable; the last-pair register survives for hold mode.
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            sample_d = 32'h0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d  = S_PREFILL;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    level_d  = '0;
                    sample_d = 32'h0;
                end
                S_PREFILL: begin
                    if (next) begin
                        sample_d = hold_pair;
                    end
                    if (level_q >= LVL_PRE) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (pop) begin
                        sample_d = head;
                        last_d   = head;
                    end else if (underrun) begin
                        sample_d = hold_pair;
                        state_d  = S_PREFILL;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Clear has priority over a simultaneous underrun.
        if (clr_underrun) begin
            ucnt_d = 16'h0;
        end else if (underrun && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sample_q <= 32'h0;
            last_q   <= 32'h0;
            ucnt_q   <= 16'h0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sample_q <= sample_d;
            last_q   <= last_d;
            ucnt_q   <= ucnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem_q[wr_ptr_q] <= {wr_l, wr_r};
        end
    end

    always_comb begin
        sample_l     = sample_q[31:16];
        sample_r     = sample_q[15:0];
        level        = level_q;
        running      = (state_q == S_RUN);
        low          = running && (level_q < LVL_LOW);
        underrun_cnt = ucnt_q;
    end

endmodule
